rf_write_scheduler: RTL and testbench
=====================================

# rf_write_scheduler

Write-port scheduler for the 16×32 register file. The register file has a single write port (PW, C, RFLd). Some instructions retire two writes in the same cycle, e.g. a load result plus a base-register update. This block accepts up to two write requests per cycle and serialises them onto that port in program order, buffering the surplus in a small FIFO. It also provides stall, pending-write hazard and R15-write indications to pipeline control.

## Interface
Parameters:
- DEPTH, 2: pending-write FIFO entries; legal values ≥ 2.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- WA_VALID  in  1  primary write request (older in program order).
- WA_REG  in  4  primary destination register.
- WA_DATA  in  32  primary write data.
- WB_VALID  in  1  secondary write request (younger in program order).
- WB_REG  in  4  secondary destination register.
- WB_DATA  in  32  secondary write data.
- QA_REG  in  4  hazard query register A (decode-stage source).
- QB_REG  in  4  hazard query register B.
- QA_HIT  out  1  a write to QA_REG is queued or on the port this cycle.
- QB_HIT  out  1  same as QA_HIT, for QB_REG.
- PW  out  32  register-file write data (registered).
- C  out  4  register-file write select (registered).
- RFLd  out  1  register-file write enable (registered).
- PC_WRITE  out  1  registered; high when RFLd=1 and C=4'hF.
- STALL  out  1  upstream must not present requests.
- ERR  out  1  sticky; set when a request arrives while STALL=1.

## Operation
- State:
  - FIFO of {reg, data}, DEPTH entries.
  - occupancy count of width clog2(DEPTH+1).
  - output registers PW, C, RFLd, PC_WRITE.
  - ERR flag.
- Candidate order each cycle: FIFO entries (oldest first), then A (if WA_VALID), then B (if WB_VALID).
- Each cycle, if any candidate exists:
  - The first candidate is issued to the output registers.
  - Remaining arrivals are enqueued in the same order.
  - next_count = count + arrivals − 1.
- With no candidates: RFLd←0, PC_WRITE←0, and PW/C hold their previous values.
- A single arrival with an empty FIFO bypasses the FIFO (issued directly).
- STALL = (count ≥ DEPTH−1), decoded from registered count only, never from the request inputs. Following this rule the FIFO never exceeds DEPTH entries.
- Requests presented while STALL=1:
  - are discarded (neither issued nor enqueued);
  - set ERR, which clears only on reset.
- Same destination in A and B: both are written in order, so B's data is final.
- QA_HIT/QB_HIT are combinational over registered state only. Hit = (any valid FIFO entry with matching reg) OR (RFLd=1 and C matches).
- Query and write inputs in the same cycle do not affect the hit outputs in that cycle.
- R15 writes are scheduled like any other register. PC_WRITE is provided so pipeline control can gate HZPCld.

## Timing
- Reset (RST=0, asynchronous):
  - count=0; all FIFO entries invalid.
  - PW=0, C=0, RFLd=0, PC_WRITE=0, STALL=0, ERR=0.
  - QA_HIT=QB_HIT=0.
- Reset mid-operation discards all pending writes; none reach the register file.
- Latency: a request sampled at edge N appears on PW/C/RFLd for cycle N→N+1. The register file latches it at edge N+1.
- Dual request into an empty FIFO:
  - A on the port in cycle N+1, B in cycle N+2.
  - count=1 during cycle N+1.
- STALL rises the cycle after the edge at which count reaches DEPTH−1. It falls the cycle after count drops below DEPTH−1.
- Throughput: one write per cycle sustained. Continuous dual requests stall roughly every other cycle once the FIFO fills.
- Wrap-around: FIFO read/write pointers wrap modulo DEPTH, and ordering is preserved across the wrap.

## Test plan
- Reset: hold RST=0 with random requests → all outputs 0. Release with idle inputs for 5 cycles → outputs remain 0, ERR=0.
- Single write: WA_VALID, R3=0x11 at edge 0 → cycle 1: RFLd=1, C=3, PW=0x11. Cycle 2: RFLd=0. QA_REG=3 gives QA_HIT=1 only in cycle 1.
- Dual write: A R1=0xA and B R2=0xB at edge 0, DEPTH=2:
  - cycle 1: C=1, PW=0xA, STALL=1; QB_REG=2 → QB_HIT=1.
  - cycle 2: C=2, PW=0xB; QB_HIT=1.
  - cycle 3: STALL=0, QB_HIT=0.
- Overrun: dual request at edge 0, then another dual request while STALL=1 → second pair never written; ERR=1 persists until reset.
- Ordering: A R5=0x1 and B R5=0x2 → register file R5 reads 0x2 after cycle 2. Write R15=0x40 → PC_WRITE=1 together with RFLd=1, C=0xF.
- Wrap and reset: DEPTH=4, 12 alternating single/dual requests honouring STALL → port sequence matches program order exactly. Repeat and assert RST=0 with count=2 → no further RFLd pulses.

Source files
------------

// File: rtl/rf_write_scheduler_if.sv
// Request, hazard-query and register-file port bundle for rf_write_scheduler.
interface rf_write_scheduler_if;
  logic        WA_VALID;
  logic [3:0]  WA_REG;
  logic [31:0] WA_DATA;
  logic        WB_VALID;
  logic [3:0]  WB_REG;
  logic [31:0] WB_DATA;
  logic [3:0]  QA_REG;
  logic [3:0]  QB_REG;
  logic        QA_HIT;
  logic        QB_HIT;
  logic [31:0] PW;
  logic [3:0]  C;
  logic        RFLd;
  logic        PC_WRITE;
  logic        STALL;
  logic        ERR;

  modport master (
    output WA_VALID, WA_REG, WA_DATA, WB_VALID, WB_REG, WB_DATA, QA_REG, QB_REG,
    input  QA_HIT, QB_HIT, PW, C, RFLd, PC_WRITE, STALL, ERR
  );

  modport slave (
    input  WA_VALID, WA_REG, WA_DATA, WB_VALID, WB_REG, WB_DATA, QA_REG, QB_REG,
    output QA_HIT, QB_HIT, PW, C, RFLd, PC_WRITE, STALL, ERR
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Serialises up to two register-file writes per cycle onto the single write
// port in program order; surplus writes wait in a small FIFO.
module rf_write_scheduler #(
  parameter int DEPTH = 2
) (
  input logic           CLK,
  input logic           RST,
  rf_write_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  rg;
    logic [31:0] data;
  } ent_t;

  ent_t             fifo [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             stall, err_q;

  logic             a_v, b_v, arr0_v, arr1_v;
  ent_t             arr0, arr1;
  logic             iss_v, deq, e0_v, e1_v;
  ent_t             iss, e0, e1;
  logic [CW-1:0]    n_arr;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Stall comes only from registered occupancy, so accepting at most two
  // arrivals (one of which always issues) can never overfill the FIFO.
  assign stall = (count >= CW'(DEPTH - 1));

  // Pick the issue candidate (FIFO head, else A, else B) and the arrivals to enqueue.
  always_comb begin
    a_v    = bus.WA_VALID & ~stall;
    b_v    = bus.WB_VALID & ~stall;
    arr0   = a_v ? {bus.WA_REG, bus.WA_DATA} : {bus.WB_REG, bus.WB_DATA};
    arr0_v = a_v | b_v;
    arr1   = {bus.WB_REG, bus.WB_DATA};
    arr1_v = a_v & b_v;
    n_arr  = CW'(a_v) + CW'(b_v);
    iss    = arr0;
    iss_v  = arr0_v;
    deq    = 1'b0;
    e0     = arr1;
    e0_v   = arr1_v;
    e1     = arr1;
    e1_v   = 1'b0;
    if (count != '0) begin
      iss   = fifo[rd_ptr];
      iss_v = 1'b1;
      deq   = 1'b1;
      e0    = arr0;
      e0_v  = arr0_v;
      e1    = arr1;
      e1_v  = arr1_v;
    end
  end

  // Pointers, occupancy, entry valids, port registers and sticky error.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      vld          <= '0;
      bus.PW       <= '0;
      bus.C        <= '0;
      bus.RFLd     <= 1'b0;
      bus.PC_WRITE <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (deq) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= inc(rd_ptr);
      end
      if (e0_v) vld[wr_ptr] <= 1'b1;
      if (e1_v) vld[inc(wr_ptr)] <= 1'b1;
      if (e1_v)      wr_ptr <= inc(inc(wr_ptr));
      else if (e0_v) wr_ptr <= inc(wr_ptr);
      if (iss_v) count <= count + n_arr - CW'(1);
      bus.RFLd     <= iss_v;
      bus.PC_WRITE <= iss_v & (iss.rg == 4'hF);
      if (iss_v) begin
        bus.PW <= iss.data;
        bus.C  <= iss.rg;
      end
      if (stall & (bus.WA_VALID | bus.WB_VALID)) err_q <= 1'b1;
    end
  end

  // FIFO payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge CLK) begin
    if (e0_v) fifo[wr_ptr] <= e0;
    if (e1_v) fifo[inc(wr_ptr)] <= e1;
  end

  // Hazard hits look only at registered state: queued entries and the port.
  always_comb begin
    bus.QA_HIT = bus.RFLd & (bus.C == bus.QA_REG);
    bus.QB_HIT = bus.RFLd & (bus.C == bus.QB_REG);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && fifo[i].rg == bus.QA_REG) bus.QA_HIT = 1'b1;
      if (vld[i] && fifo[i].rg == bus.QB_REG) bus.QB_HIT = 1'b1;
    end
  end

  assign bus.STALL = stall;
  assign bus.ERR   = err_q;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: DEPTH=2 and DEPTH=4 instances.
module tb_rf_write_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_write_scheduler_if b2();
  rf_write_scheduler_if b4();

  rf_write_scheduler #(.DEPTH(2)) dut2 (.CLK(clk), .RST(rst_n), .bus(b2.slave));
  rf_write_scheduler #(.DEPTH(4)) dut4 (.CLK(clk), .RST(rst_n), .bus(b4.slave));

  int vec = 0;
  int err = 0;

  logic [31:0] rf2 [16];
  logic [35:0] log4 [$];
  logic [35:0] exp4 [$];

  // Register file behind dut2 and write-port trace of dut4.
  always @(posedge clk) if (b2.RFLd) rf2[b2.C] = b2.PW;
  always @(posedge clk) if (b4.RFLd) log4.push_back({b4.C, b4.PW});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b2.WA_VALID = 0; b2.WA_REG = 0; b2.WA_DATA = 0;
    b2.WB_VALID = 0; b2.WB_REG = 0; b2.WB_DATA = 0;
    b2.QA_REG = 0; b2.QB_REG = 0;
    b4.WA_VALID = 0; b4.WA_REG = 0; b4.WA_DATA = 0;
    b4.WB_VALID = 0; b4.WB_REG = 0; b4.WB_DATA = 0;
    b4.QA_REG = 0; b4.QB_REG = 0;
  endtask

  task automatic test_reset();
    logic [42:0] o2, o4;
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      b2.WA_VALID = 1'($urandom); b2.WA_REG = 4'($urandom); b2.WA_DATA = $urandom;
      b2.WB_VALID = 1'($urandom); b2.WB_REG = 4'($urandom); b2.WB_DATA = $urandom;
      b2.QA_REG = 4'($urandom); b2.QB_REG = 4'($urandom);
      b4.WA_VALID = 1; b4.WA_REG = 4'($urandom); b4.WA_DATA = $urandom;
      b4.WB_VALID = 1; b4.WB_REG = 4'($urandom); b4.WB_DATA = $urandom;
      b4.QA_REG = 4'($urandom); b4.QB_REG = 4'($urandom);
      tick();
      o2 = {b2.PW, b2.C, b2.RFLd, b2.PC_WRITE, b2.STALL, b2.ERR, b2.QA_HIT, b2.QB_HIT};
      o4 = {b4.PW, b4.C, b4.RFLd, b4.PC_WRITE, b4.STALL, b4.ERR, b4.QA_HIT, b4.QB_HIT};
      vec++; if (o2 !== '0) begin err++; $display("FAIL reset_hold_d2: got %h want 0", o2); end
      vec++; if (o4 !== '0) begin err++; $display("FAIL reset_hold_d4: got %h want 0", o4); end
    end
    idle();
    foreach (rf2[i]) rf2[i] = 0;
    rst_n = 1;
    for (int i = 0; i < 5; i++) tick();
    o2 = {b2.PW, b2.C, b2.RFLd, b2.PC_WRITE, b2.STALL, b2.ERR, b2.QA_HIT, b2.QB_HIT};
    o4 = {b4.PW, b4.C, b4.RFLd, b4.PC_WRITE, b4.STALL, b4.ERR, b4.QA_HIT, b4.QB_HIT};
    vec++; if (o2 !== '0) begin err++; $display("FAIL reset_idle_d2: got %h want 0", o2); end
    vec++; if (o4 !== '0) begin err++; $display("FAIL reset_idle_d4: got %h want 0", o4); end
  endtask

  task automatic test_single();
    idle();
    b2.WA_VALID = 1; b2.WA_REG = 4'd3; b2.WA_DATA = 32'h11; b2.QA_REG = 4'd3;
    tick();
    idle(); b2.QA_REG = 4'd3;
    vec++; if ({b2.RFLd, b2.C, b2.PW} !== {1'b1, 4'd3, 32'h11})
      begin err++; $display("FAIL single_c1_port: got %b/%h/%h want 1/3/11", b2.RFLd, b2.C, b2.PW); end
    vec++; if (b2.QA_HIT !== 1'b1) begin err++; $display("FAIL single_c1_hit: got %b want 1", b2.QA_HIT); end
    vec++; if (b2.STALL !== 1'b0) begin err++; $display("FAIL single_c1_stall: got %b want 0", b2.STALL); end
    tick();
    vec++; if ({b2.RFLd, b2.C, b2.PW} !== {1'b0, 4'd3, 32'h11})
      begin err++; $display("FAIL single_c2_port: got %b/%h/%h want 0/3/11", b2.RFLd, b2.C, b2.PW); end
    vec++; if (b2.QA_HIT !== 1'b0) begin err++; $display("FAIL single_c2_hit: got %b want 0", b2.QA_HIT); end
  endtask

  task automatic test_dual();
    idle();
    b2.WA_VALID = 1; b2.WA_REG = 4'd1; b2.WA_DATA = 32'hA;
    b2.WB_VALID = 1; b2.WB_REG = 4'd2; b2.WB_DATA = 32'hB;
    b2.QB_REG = 4'd2;
    tick();
    idle(); b2.QB_REG = 4'd2;
    vec++; if ({b2.RFLd, b2.C, b2.PW, b2.STALL} !== {1'b1, 4'd1, 32'hA, 1'b1})
      begin err++; $display("FAIL dual_c1: got %b/%h/%h stall %b want 1/1/a stall 1", b2.RFLd, b2.C, b2.PW, b2.STALL); end
    vec++; if (b2.QB_HIT !== 1'b1) begin err++; $display("FAIL dual_c1_hit: got %b want 1", b2.QB_HIT); end
    tick();
    vec++; if ({b2.RFLd, b2.C, b2.PW} !== {1'b1, 4'd2, 32'hB})
      begin err++; $display("FAIL dual_c2: got %b/%h/%h want 1/2/b", b2.RFLd, b2.C, b2.PW); end
    vec++; if (b2.QB_HIT !== 1'b1) begin err++; $display("FAIL dual_c2_hit: got %b want 1", b2.QB_HIT); end
    tick();
    vec++; if ({b2.STALL, b2.QB_HIT, b2.RFLd} !== 3'b000)
      begin err++; $display("FAIL dual_c3: got stall/hit/rfld %b%b%b want 000", b2.STALL, b2.QB_HIT, b2.RFLd); end
    vec++; if ({rf2[1], rf2[2]} !== {32'hA, 32'hB})
      begin err++; $display("FAIL dual_rf: got %h %h want a b", rf2[1], rf2[2]); end
  endtask

  task automatic test_overrun();
    idle();
    b2.WA_VALID = 1; b2.WA_REG = 4'd6; b2.WA_DATA = 32'h66;
    b2.WB_VALID = 1; b2.WB_REG = 4'd7; b2.WB_DATA = 32'h77;
    tick();
    vec++; if (b2.STALL !== 1'b1) begin err++; $display("FAIL overrun_stall: got %b want 1", b2.STALL); end
    b2.WA_REG = 4'd8; b2.WA_DATA = 32'h88;
    b2.WB_REG = 4'd9; b2.WB_DATA = 32'h99;
    tick();
    idle();
    vec++; if ({b2.C, b2.PW, b2.ERR} !== {4'd7, 32'h77, 1'b1})
      begin err++; $display("FAIL overrun_c2: got %h/%h err %b want 7/77 err 1", b2.C, b2.PW, b2.ERR); end
    for (int i = 0; i < 4; i++) tick();
    vec++; if ({rf2[8], rf2[9]} !== 64'h0)
      begin err++; $display("FAIL overrun_dropped: got %h %h want 0 0", rf2[8], rf2[9]); end
    vec++; if ({rf2[6], rf2[7]} !== {32'h66, 32'h77})
      begin err++; $display("FAIL overrun_kept: got %h %h want 66 77", rf2[6], rf2[7]); end
    vec++; if (b2.ERR !== 1'b1) begin err++; $display("FAIL overrun_sticky: got %b want 1", b2.ERR); end
    rst_n = 0;
    #1;
    vec++; if (b2.ERR !== 1'b0) begin err++; $display("FAIL overrun_clear: got %b want 0", b2.ERR); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_ordering();
    idle();
    b2.WA_VALID = 1; b2.WA_REG = 4'd5; b2.WA_DATA = 32'h1;
    b2.WB_VALID = 1; b2.WB_REG = 4'd5; b2.WB_DATA = 32'h2;
    tick(); idle();
    tick(); tick();
    vec++; if (rf2[5] !== 32'h2) begin err++; $display("FAIL order_same_reg: got %h want 2", rf2[5]); end
    b2.WB_VALID = 1; b2.WB_REG = 4'd4; b2.WB_DATA = 32'h44;
    tick(); idle();
    vec++; if ({b2.RFLd, b2.C, b2.PW} !== {1'b1, 4'd4, 32'h44})
      begin err++; $display("FAIL b_only: got %b/%h/%h want 1/4/44", b2.RFLd, b2.C, b2.PW); end
    tick();
    b2.WA_VALID = 1; b2.WA_REG = 4'hF; b2.WA_DATA = 32'h40;
    tick(); idle();
    vec++; if ({b2.PC_WRITE, b2.RFLd, b2.C, b2.PW} !== {1'b1, 1'b1, 4'hF, 32'h40})
      begin err++; $display("FAIL pc_write: got %b/%b/%h/%h want 1/1/f/40", b2.PC_WRITE, b2.RFLd, b2.C, b2.PW); end
    tick();
    vec++; if (b2.PC_WRITE !== 1'b0) begin err++; $display("FAIL pc_write_drop: got %b want 0", b2.PC_WRITE); end
  endtask

  task automatic test_wrap_reset();
    int k, n, base;
    idle();
    log4.delete(); exp4.delete();
    k = 0;
    for (int i = 0; i < 12; i++) begin
      n = 0;
      while (b4.STALL && n < 20) begin tick(); n++; end
      if (n == 20) begin vec++; err++; $display("FAIL wrap_stall_timeout: stall stuck at req %0d", i); end
      b4.WA_VALID = 1; b4.WA_REG = 4'(k % 15); b4.WA_DATA = 32'h100 + k;
      exp4.push_back({4'(k % 15), 32'h100 + k}); k++;
      if (i % 2 == 1) begin
        b4.WB_VALID = 1; b4.WB_REG = 4'(k % 15); b4.WB_DATA = 32'h100 + k;
        exp4.push_back({4'(k % 15), 32'h100 + k}); k++;
      end
      tick(); idle();
    end
    for (int i = 0; i < 10; i++) tick();
    vec++; if (log4.size() != exp4.size())
      begin err++; $display("FAIL wrap_count: got %0d want %0d", log4.size(), exp4.size()); end
    for (int i = 0; i < exp4.size() && i < log4.size(); i++) begin
      vec++; if (log4[i] !== exp4[i])
        begin err++; $display("FAIL wrap_seq[%0d]: got %h want %h", i, log4[i], exp4[i]); end
    end
    vec++; if (b4.ERR !== 1'b0) begin err++; $display("FAIL wrap_err: got %b want 0", b4.ERR); end

    base = log4.size();
    b4.WA_VALID = 1; b4.WA_REG = 4'd10; b4.WA_DATA = 32'hA0;
    b4.WB_VALID = 1; b4.WB_REG = 4'd11; b4.WB_DATA = 32'hA1;
    tick();
    b4.WA_REG = 4'd12; b4.WA_DATA = 32'hA2;
    b4.WB_REG = 4'd13; b4.WB_DATA = 32'hA3;
    tick(); idle();
    b4.QA_REG = 4'd12; b4.QB_REG = 4'd13;
    #1;
    vec++; if ({b4.QA_HIT, b4.QB_HIT, b4.C} !== {1'b1, 1'b1, 4'd11})
      begin err++; $display("FAIL pre_reset_q: got hit %b%b c %h want 11 c b", b4.QA_HIT, b4.QB_HIT, b4.C); end
    rst_n = 0;
    #1;
    vec++; if ({b4.RFLd, b4.QA_HIT, b4.QB_HIT} !== 3'b000)
      begin err++; $display("FAIL mid_reset: got rfld/hits %b%b%b want 000", b4.RFLd, b4.QA_HIT, b4.QB_HIT); end
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) tick();
    vec++; if (log4.size() != base + 1)
      begin err++; $display("FAIL reset_discard: got %0d writes want %0d", log4.size(), base + 1); end
    vec++; if (b4.RFLd !== 1'b0) begin err++; $display("FAIL reset_rfld: got %b want 0", b4.RFLd); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_dual();
    test_overrun();
    test_ordering();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
